pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/memory-wait hazard control and registered EX forwarding selects.
// Optional HAZ_PERF_CNT_EN adds saturating stall, flush and timeout counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rn_id,
    input  logic [4:0] Rm_id,
    input  logic       uses_rm_id,
    input  logic [4:0] Rd_ex,
    input  logic       RegWrite_ex,
    input  logic       MemtoReg_ex,
    input  logic [4:0] Rd_mem,
    input  logic       RegWrite_mem,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       branch_taken_mem,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_bubble,
    output logic [1:0] fwdA_ex,
    output logic [1:0] fwdB_ex,
    output logic       mem_err,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events,
    output logic [7:0]  timeouts,
`endif
    output logic       in_mem_wait
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic             mem_err_q, mem_err_d;
    logic             waiting, freeze, brk, lu, rel, tmo, hold;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] rd_e, input logic ex_ok,
                                           input logic [4:0] rd_m, input logic mem_ok);
        return (ex_ok && rd_e != 5'd31 && rd_e == src) ? 2'b01 :
               (mem_ok && rd_m != 5'd31 && rd_m == src) ? 2'b10 : 2'b00;
    endfunction

    // XZR (r31) never creates a dependency
    assign waiting = state_q == MEM_WAIT;
    assign freeze  = !waiting && mem_req && !mem_ready;
    assign brk     = !waiting && !freeze && branch_taken_mem;
    assign lu      = !waiting && !freeze && !branch_taken_mem && RegWrite_ex && MemtoReg_ex && Rd_ex != 5'd31 &&
                     (Rd_ex == Rn_id || (uses_rm_id && Rd_ex == Rm_id));
    assign rel     = waiting && mem_ready;
    assign tmo     = waiting && !mem_ready && cnt_q == CNT_W'(MEM_TIMEOUT);
    assign hold    = waiting && !rel && !tmo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = freeze ? MEM_WAIT : (rel || tmo) ? RUN : state_q;
        cnt_d     = freeze ? CNT_W'(1) : (rel || tmo) ? '0 : waiting ? cnt_q + 1'b1 : cnt_q;
        mem_err_d = tmo;
        fwd_a_d   = (brk || lu) ? 2'b00 :
                    (id_ex_en && !ex_mem_flush) ? fwd_sel(Rn_id, Rd_ex, RegWrite_ex && !MemtoReg_ex, Rd_mem, RegWrite_mem) : fwd_a_q;
        fwd_b_d   = (brk || lu) ? 2'b00 :
                    (id_ex_en && !ex_mem_flush) ? fwd_sel(Rm_id, Rd_ex, RegWrite_ex && !MemtoReg_ex, Rd_mem, RegWrite_mem) : fwd_b_q;
    end

    always_comb begin
        pc_en         = !(freeze || hold || lu);
        if_id_en      = !(freeze || hold || lu);
        id_ex_en      = !(freeze || hold);
        ex_mem_en     = !(freeze || hold);
        if_id_flush   = brk;
        id_ex_flush   = brk || lu;
        ex_mem_flush  = brk || tmo;
        mem_wb_bubble = freeze || (waiting && !rel);
        in_mem_wait   = waiting;
    end

    assign fwdA_ex = fwd_a_q;
    assign fwdB_ex = fwd_b_q;
    assign mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic [7:0]  tmo_q, tmo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
            tmo_q   <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        stall_d = (!pc_en && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        flush_d = (brk && flush_q != '1) ? flush_q + 16'd1 : flush_q;
        tmo_d   = (tmo && tmo_q != '1) ? tmo_q + 8'd1 : tmo_q;
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
    assign timeouts     = tmo_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven RUN-state vectors plus wait, timeout and reset sequences.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rn_id, Rm_id, Rd_ex, Rd_mem;
    logic       uses_rm_id, RegWrite_ex, MemtoReg_ex, RegWrite_mem, mem_req, mem_ready, branch_taken_mem;
    logic       a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_bub, a_err, a_wait;
    logic       b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fexmem, b_bub, b_err, b_wait;
    logic [1:0] a_fa, a_fb, b_fa, b_fb;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] a_stall, b_stall;
    logic [15:0] a_flush, b_flush;
    logic [7:0]  a_tmo, b_tmo;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .Rn_id(Rn_id), .Rm_id(Rm_id), .uses_rm_id(uses_rm_id),
        .Rd_ex(Rd_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .Rd_mem(Rd_mem),
        .RegWrite_mem(RegWrite_mem), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken_mem(branch_taken_mem),
        .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
        .if_id_flush(a_fifid), .id_ex_flush(a_fidex), .ex_mem_flush(a_fexmem), .mem_wb_bubble(a_bub),
        .fwdA_ex(a_fa), .fwdB_ex(a_fb), .mem_err(a_err),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles(a_stall), .flush_events(a_flush), .timeouts(a_tmo),
`endif
        .in_mem_wait(a_wait)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .Rn_id(Rn_id), .Rm_id(Rm_id), .uses_rm_id(uses_rm_id),
        .Rd_ex(Rd_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .Rd_mem(Rd_mem),
        .RegWrite_mem(RegWrite_mem), .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken_mem(branch_taken_mem),
        .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
        .if_id_flush(b_fifid), .id_ex_flush(b_fidex), .ex_mem_flush(b_fexmem), .mem_wb_bubble(b_bub),
        .fwdA_ex(b_fa), .fwdB_ex(b_fb), .mem_err(b_err),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles(b_stall), .flush_events(b_flush), .timeouts(b_tmo),
`endif
        .in_mem_wait(b_wait)
    );

    typedef struct {
        logic [4:0] rn, rm;
        logic       urm;
        logic [4:0] rdex;
        logic       rwex, m2r;
        logic [4:0] rdmem;
        logic       rwmem, br, mreq, mrdy;
        logic [7:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Rn_id = v.rn; Rm_id = v.rm; uses_rm_id = v.urm; Rd_ex = v.rdex; RegWrite_ex = v.rwex;
        MemtoReg_ex = v.m2r; Rd_mem = v.rdmem; RegWrite_mem = v.rwmem; branch_taken_mem = v.br;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    function automatic logic [7:0] a_ctl();
        return {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_bub};
    endfunction

    initial begin
        //          rn     rm     urm   rdex   rwex  m2r   rdmem  rwmem br    mreq  mrdy  ctl    fa     fb
        vecs[0]  = '{5'd1,  5'd2,  1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd0, 2'd0};
        vecs[1]  = '{5'd3,  5'd2,  1'b1, 5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 8'h34, 2'd0, 2'd0};
        vecs[2]  = '{5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd0, 2'd0};
        vecs[3]  = '{5'd1,  5'd7,  1'b1, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h34, 2'd0, 2'd0};
        vecs[4]  = '{5'd1,  5'd7,  1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd0, 2'd0};
        vecs[5]  = '{5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd1, 2'd1};
        vecs[6]  = '{5'd5,  5'd5,  1'b1, 5'd6,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd2, 2'd2};
        vecs[7]  = '{5'd3,  5'd2,  1'b1, 5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 2'd0, 2'd0};
        vecs[8]  = '{5'd5,  5'd6,  1'b1, 5'd6,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd2, 2'd1};
        vecs[9]  = '{5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 2'd0, 2'd0};
        vecs[10] = '{5'd31, 5'd31, 1'b1, 5'd0,  1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd0, 2'd0};
        vecs[11] = '{5'd5,  5'd6,  1'b1, 5'd6,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 2'd2, 2'd1};
        vecs[12] = '{5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 2'd1, 2'd1};

        reset = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("reset_ctl", {24'd0, a_ctl()}, 32'hF0);
        chk("reset_fwdA", {30'd0, a_fa}, 32'd0);
        chk("reset_fwdB", {30'd0, a_fb}, 32'd0);
        chk("reset_wait", {31'd0, a_wait}, 32'd0);
        chk("reset_err", {31'd0, a_err}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctl", i), {24'd0, a_ctl()}, {24'd0, vecs[i].ctl});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_fwdA", i), {30'd0, a_fa}, {30'd0, vecs[i].fa});
            chk($sformatf("vec%0d_fwdB", i), {30'd0, a_fb}, {30'd0, vecs[i].fb});
        end
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_table", a_stall, 32'd2);
        chk("perf_flush_table", {16'd0, a_flush}, 32'd2);
`endif

        // four frozen cycles then release; forwarding must hold the 01 left by vecs[12]
        RegWrite_ex = 1'b0; RegWrite_mem = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            branch_taken_mem = (i == 2);
            #1;
            chk($sformatf("wait%0d_pc", i), {31'd0, a_pc}, 32'd0);
            chk($sformatf("wait%0d_exmem", i), {31'd0, a_exmem}, 32'd0);
            chk($sformatf("wait%0d_bub", i), {31'd0, a_bub}, 32'd1);
            chk($sformatf("wait%0d_inwait", i), {31'd0, a_wait}, {31'd0, i != 0});
            chk($sformatf("wait%0d_flush", i), {29'd0, a_fifid, a_fidex, a_fexmem}, 32'd0);
            chk($sformatf("wait%0d_fwdA", i), {30'd0, a_fa}, 32'd1);
            @(posedge clk);
            #1;
        end
        branch_taken_mem = 1'b0; mem_ready = 1'b1;
        #1;
        chk("release_ctl", {24'd0, a_ctl()}, 32'hF0);
        chk("release_inwait", {31'd0, a_wait}, 32'd1);
        @(posedge clk);
        #1;
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("after_release_inwait", {31'd0, a_wait}, 32'd0);
        chk("after_release_pc", {31'd0, a_pc}, 32'd1);
        chk("after_release_err", {31'd0, a_err}, 32'd0);

        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // dut_b times out after three MEM_WAIT cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("tmo%0d_pc", c), {31'd0, b_pc}, 32'd0);
            chk($sformatf("tmo%0d_exflush", c), {31'd0, b_fexmem}, 32'd0);
            @(posedge clk);
            #1;
        end
        #1;
        chk("tmo3_exflush", {31'd0, b_fexmem}, 32'd1);
        chk("tmo3_pc", {31'd0, b_pc}, 32'd1);
        chk("tmo3_inwait", {31'd0, b_wait}, 32'd1);
        chk("tmo3_err", {31'd0, b_err}, 32'd0);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        #1;
        chk("tmo4_inwait", {31'd0, b_wait}, 32'd0);
        chk("tmo4_err", {31'd0, b_err}, 32'd1);
        chk("tmo4_pc", {31'd0, b_pc}, 32'd1);
        @(posedge clk);
        #1;
        chk("tmo5_err", {31'd0, b_err}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_timeouts", {24'd0, b_tmo}, 32'd1);
        chk("perf_stall_tmo", b_stall, 32'd3);
`endif

        // dut_a is still waiting; async reset must drop it back to RUN at once
        chk("a_still_wait", {31'd0, a_wait}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_wait", {31'd0, a_wait}, 32'd0);
        chk("async_reset_pc", {31'd0, a_pc}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
